// File: rtl/alu_exec.sv
// alu_exec: two-stage valid/ready ALU (add, sub, and, or, slt) with illegal-code flag and count.
// Optional macro ALU_OVF_EN adds the ovf output for signed add/sub overflow.
module alu_exec #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err,
  output logic [7:0]       err_count
`ifdef ALU_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_SLT = 3'd5;

  logic             s1_valid;
  logic [2:0]       s1_ctrl;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_result;
  logic             s2_zero;
  logic             s2_err;

  logic             in_fire;
  logic             out_fire;
  logic             s1_adv;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] alu_result;
  logic             alu_err;

  // S1 may move on whenever S2 is empty or is being drained this cycle
  assign out_fire = s2_valid && out_ready;
  assign s1_adv   = s1_valid && (!s2_valid || out_ready);
  assign in_ready = !s1_valid || s1_adv;
  assign in_fire  = in_valid && in_ready;

  assign sum  = s1_a + s1_b;
  assign diff = s1_a - s1_b;

  always_comb begin
    alu_result = '0;
    alu_err    = 1'b0;
    case (s1_ctrl)
      OP_ADD:  alu_result = sum;
      OP_SUB:  alu_result = diff;
      OP_AND:  alu_result = s1_a & s1_b;
      OP_OR:   alu_result = s1_a | s1_b;
      OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(s1_a) < $signed(s1_b))};
      default: alu_err    = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_ctrl  <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_ctrl  <= alu_ctrl;
      s1_a     <= a;
      s1_b     <= b;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // S2 payload only changes on a load, so it stays put under backpressure
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_zero   <= 1'b0;
      s2_err    <= 1'b0;
    end else if (s1_adv) begin
      s2_valid  <= 1'b1;
      s2_result <= alu_result;
      s2_zero   <= (alu_result == '0);
      s2_err    <= alu_err;
    end else if (out_fire) begin
      s2_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= 8'd0;
    end else if (out_fire && s2_err && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end

`ifdef ALU_OVF_EN
  logic ovf_add;
  logic ovf_sub;
  logic s2_ovf;

  assign ovf_add = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (sum[WIDTH-1]  != s1_a[WIDTH-1]);
  assign ovf_sub = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (diff[WIDTH-1] != s1_a[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_ovf <= 1'b0;
    end else if (s1_adv) begin
      s2_ovf <= ((s1_ctrl == OP_ADD) && ovf_add) || ((s1_ctrl == OP_SUB) && ovf_sub);
    end
  end

  assign ovf = s2_ovf;
`endif

  assign out_valid = s2_valid;
  assign result    = s2_result;
  assign zero      = s2_zero;
  assign err       = s2_err;

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed scenarios plus randomized traffic checked against a queue-based
// reference model of alu_exec (32-bit); ovf checks are compiled in when ALU_OVF_EN is defined.
module tb_alu_exec;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        err;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  alu_ctrl = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        err;
  logic [7:0]  err_count;
`ifdef ALU_OVF_EN
  logic        ovf;
`endif

  int checks = 0;
  int errors = 0;

  alu_exec #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .err       (err),
    .err_count (err_count)
`ifdef ALU_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reference: true signed result computed wide; overflow means it does not fit in 32 bits
  function automatic exp_t ref_op(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y);
    exp_t   e;
    longint sx;
    longint sy;
    longint wide;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e  = '0;
    case (c)
      3'd1: begin wide = sx + sy; e.result = wide[31:0]; e.ovf = (wide != longint'($signed(e.result))); end
      3'd2: begin wide = sx - sy; e.result = wide[31:0]; e.ovf = (wide != longint'($signed(e.result))); end
      3'd3: e.result = x & y;
      3'd4: e.result = x | y;
      3'd5: e.result = (sx < sy) ? 32'd1 : 32'd0;
      default: e.err = 1'b1;
    endcase
    e.zero = (e.result == 32'd0);
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] c, input logic [31:0] x, input logic [31:0] y);
    in_valid = v;
    alu_ctrl = c;
    a        = x;
    b        = y;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    out_ready = 1'b0;
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0);
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    out_ready = 1'b1;
    applyStimulus(1'b1, 3'd1, 32'd4, 32'd4);
    tick;
    tick;
    reset = 1'b0;
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b expected 0", out_valid); end
    checks++; if (result !== 32'd0) begin errors++; $display("[TB] FAIL reset_result got %h expected 0", result); end
    checks++; if (zero !== 1'b0) begin errors++; $display("[TB] FAIL reset_zero got %b expected 0", zero); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b expected 0", err); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_err_count got %0d expected 0", err_count); end
`ifdef ALU_OVF_EN
    checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf got %b expected 0", ovf); end
`endif
    for (int i = 0; i < 2; i++) begin
      tick;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_ignored_input got out_valid %b expected 0", out_valid); end
    end
  endtask

  task automatic test_add;
    do_reset;
    out_ready = 1'b1;
    applyStimulus(1'b1, 3'd1, 32'd5, 32'd7);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL add_in_ready got %b expected 1", in_ready); end
    tick;
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL add_latency_early got out_valid %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL add_in_ready_mid got %b expected 1", in_ready); end
    tick;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL add_out_valid got %b expected 1", out_valid); end
    checks++; if (result !== 32'd12) begin errors++; $display("[TB] FAIL add_result got %h expected %h", result, 32'd12); end
    checks++; if (zero !== 1'b0) begin errors++; $display("[TB] FAIL add_zero got %b expected 0", zero); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL add_err got %b expected 0", err); end
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL add_drained got out_valid %b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    logic [2:0]  ctrls [3];
    logic [31:0] xs    [3];
    logic [31:0] ys    [3];
    logic [31:0] rs    [3];
    logic        zs    [3];
    ctrls = '{3'd2, 3'd5, 3'd3};
    xs    = '{32'd3, 32'hFFFF_FFFF, 32'h0000_F0F0};
    ys    = '{32'd3, 32'd1, 32'h0000_0FF0};
    rs    = '{32'd0, 32'd1, 32'h0000_00F0};
    zs    = '{1'b1, 1'b0, 1'b0};
    do_reset;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c < 3) applyStimulus(1'b1, ctrls[c], xs[c], ys[c]);
      else       applyStimulus(1'b0, 3'd0, 32'd0, 32'd0);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_in_ready cycle %0d got %b expected 1", c, in_ready); end
      tick;
      if (c >= 1) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_out_valid op %0d got %b expected 1", c-1, out_valid); end
        checks++; if (result !== rs[c-1]) begin errors++; $display("[TB] FAIL b2b_result op %0d got %h expected %h", c-1, result, rs[c-1]); end
        checks++; if (zero !== zs[c-1]) begin errors++; $display("[TB] FAIL b2b_zero op %0d got %b expected %b", c-1, zero, zs[c-1]); end
      end
    end
  endtask

  task automatic test_backpressure;
    do_reset;
    out_ready = 1'b0;
    applyStimulus(1'b1, 3'd1, 32'd1, 32'd2);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_accept_first got in_ready %b expected 1", in_ready); end
    tick;
    applyStimulus(1'b1, 3'd2, 32'd10, 32'd4);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_accept_second got in_ready %b expected 1", in_ready); end
    tick;
    applyStimulus(1'b1, 3'd4, 32'd8, 32'd1);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_full got in_ready %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b1 || result !== 32'd3) begin errors++; $display("[TB] FAIL bp_head got valid %b result %h expected 1 %h", out_valid, result, 32'd3); end
    tick;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_still_full got in_ready %b expected 0", in_ready); end
    checks++; if (result !== 32'd3) begin errors++; $display("[TB] FAIL bp_hold got result %h expected %h", result, 32'd3); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release got in_ready %b expected 1", in_ready); end
    tick;
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0);
    checks++; if (out_valid !== 1'b1 || result !== 32'd6) begin errors++; $display("[TB] FAIL bp_second_out got valid %b result %h expected 1 %h", out_valid, result, 32'd6); end
    tick;
    checks++; if (out_valid !== 1'b1 || result !== 32'd9) begin errors++; $display("[TB] FAIL bp_third_out got valid %b result %h expected 1 %h", out_valid, result, 32'd9); end
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_empty got out_valid %b expected 0", out_valid); end
  endtask

  task automatic test_illegal;
    logic [2:0] codes [3];
    codes = '{3'd0, 3'd6, 3'd7};
    do_reset;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c < 3) applyStimulus(1'b1, codes[c], $urandom, $urandom);
      else       applyStimulus(1'b0, 3'd0, 32'd0, 32'd0);
      tick;
      if (c >= 1 && c <= 3) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL illegal_valid code %0d got %b expected 1", codes[c-1], out_valid); end
        checks++; if ({result, zero, err} !== {32'd0, 1'b1, 1'b1}) begin errors++; $display("[TB] FAIL illegal_out code %0d got result %h zero %b err %b expected 0 1 1", codes[c-1], result, zero, err); end
      end
    end
    checks++; if (err_count !== 8'd3) begin errors++; $display("[TB] FAIL illegal_count3 got %0d expected 3", err_count); end
    for (int i = 0; i < 257; i++) begin
      applyStimulus(1'b1, codes[$urandom_range(0, 2)], $urandom, $urandom);
      tick;
    end
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0);
    tick;
    tick;
    tick;
    checks++; if (err_count !== 8'd255) begin errors++; $display("[TB] FAIL illegal_saturate got %0d expected 255", err_count); end
  endtask

  task automatic test_reset_midflight;
    out_ready = 1'b0;
    applyStimulus(1'b1, 3'd1, 32'd100, 32'd200);
    tick;
    applyStimulus(1'b1, 3'd4, 32'd5, 32'd2);
    tick;
    reset = 1'b1;
    out_ready = 1'b1;
    applyStimulus(1'b1, 3'd3, 32'hFF, 32'hF);
    tick;
    reset = 1'b0;
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_out_valid got %b expected 0", out_valid); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("[TB] FAIL midreset_err_count got %0d expected 0", err_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_in_ready got %b expected 1", in_ready); end
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_stale cycle %0d got out_valid %b expected 0", i, out_valid); end
    end
  endtask

`ifdef ALU_OVF_EN
  task automatic test_ovf;
    logic [2:0]  ctrls [3];
    logic [31:0] xs    [3];
    logic [31:0] ys    [3];
    logic [31:0] rs    [3];
    logic        os    [3];
    ctrls = '{3'd1, 3'd2, 3'd4};
    xs    = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    ys    = '{32'd1, 32'd1, 32'h8000_0000};
    rs    = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
    os    = '{1'b1, 1'b1, 1'b0};
    do_reset;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c < 3) applyStimulus(1'b1, ctrls[c], xs[c], ys[c]);
      else       applyStimulus(1'b0, 3'd0, 32'd0, 32'd0);
      tick;
      if (c >= 1) begin
        checks++; if ({result, ovf} !== {rs[c-1], os[c-1]}) begin errors++; $display("[TB] FAIL ovf_op %0d got result %h ovf %b expected %h %b", c-1, result, ovf, rs[c-1], os[c-1]); end
      end
    end
  endtask
`endif

  task automatic test_random;
    exp_t        q[$];
    exp_t        e;
    exp_t        got;
    int          model_count;
    logic [2:0]  c;
    logic [31:0] x;
    logic [31:0] y;
    do_reset;
    model_count = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      c = 3'($urandom_range(0, 7));
      x = $urandom;
      y = ($urandom_range(0, 7) == 0) ? x : $urandom;
      applyStimulus($urandom_range(0, 3) != 0, c, x, y);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      checks++; if (in_ready !== (q.size() < 2 || out_ready)) begin errors++; $display("[TB] FAIL rand_in_ready cycle %0d got %b inflight %0d", cyc, in_ready, q.size()); end
      if (out_valid && out_ready) begin
        got = '0;
        got.result = result; got.zero = zero; got.err = err;
`ifdef ALU_OVF_EN
        got.ovf = ovf;
`endif
        if (q.size() == 0) begin
          checks++; errors++; $display("[TB] FAIL rand_spurious cycle %0d got result %h expected none", cyc, result);
        end else begin
          e = q.pop_front();
`ifndef ALU_OVF_EN
          e.ovf = 1'b0;
`endif
          checks++; if (got !== e) begin errors++; $display("[TB] FAIL rand_out cycle %0d got %h expected %h", cyc, got, e); end
          if (e.err && model_count < 255) model_count++;
        end
      end
      if (in_valid && in_ready) q.push_back(ref_op(c, x, y));
      tick;
      checks++; if (err_count !== 8'(model_count)) begin errors++; $display("[TB] FAIL rand_err_count cycle %0d got %0d expected %0d", cyc, err_count, model_count); end
    end
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      #1;
      if (out_valid) begin
        got = '0;
        got.result = result; got.zero = zero; got.err = err;
`ifdef ALU_OVF_EN
        got.ovf = ovf;
`endif
        e = q.pop_front();
`ifndef ALU_OVF_EN
        e.ovf = 1'b0;
`endif
        checks++; if (got !== e) begin errors++; $display("[TB] FAIL rand_drain got %h expected %h", got, e); end
      end
      tick;
    end
    checks++; if (q.size() != 0) begin errors++; $display("[TB] FAIL rand_drain_timeout got %0d pending expected 0", q.size()); end
  endtask

  initial begin
    $display("[TB] starting alu_exec bench");
    test_reset;
    test_add;
    test_back_to_back;
    test_backpressure;
    test_illegal;
    test_reset_midflight;
`ifdef ALU_OVF_EN
    test_ovf;
`endif
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
# alu_exec

Pipelined integer ALU execution unit for the MIPS datapath. It is the consumer side of the 3-bit ALU control code produced by the ALU controller, and executes add, subtract, AND, OR and set-less-than on two operands. It uses a two-stage valid/ready pipeline, so the execute stage can be stalled by downstream logic without losing operations. It also flags illegal control codes and keeps a saturating count of them.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits (minimum 2)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operation offered
- in_ready  output  1  unit can accept operation this cycle
- alu_ctrl  input  3  0 error, 1 add, 2 sub, 3 AND, 4 OR, 5 slt; 6/7 illegal
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts result this cycle
- result  output  WIDTH  operation result
- zero  output  1  result == 0
- err  output  1  this result came from an illegal code (0, 6, 7)
- err_count  output  8  saturating count of illegal operations accepted
- ovf  output  1  signed overflow on add/sub (present only with ALU_OVF_EN)

## Operation
- Handshake: a transfer occurs when valid && ready are both high at a rising edge.
- Stage 1 (S1) registers alu_ctrl, a and b on input transfer. Stage 2 (S2) registers computed result, zero, err and ovf.
- S1 advances into S2 when S1 is valid and (S2 is empty, or out_ready is high).
- in_ready = !S1_valid || S1 advancing. This is combinational from out_ready and gives full throughput (one op per cycle).
- Arithmetic is modulo 2^WIDTH:
  - add: a+b
  - sub: a-b
  - AND: a&b
  - OR: a|b
  - slt: signed compare, result = {WIDTH-1 zeros, (a<b signed)}
- Illegal code: result=0, zero=1, err=1, ovf=0.
- err_count increments when an err=1 result completes an output transfer, and saturates at 255.
- Outputs result, zero, err and ovf are driven from S2 registers only, and are held stable while out_valid && !out_ready.
- Simultaneous input transfer and output transfer in the same cycle: both occur and no bubble is inserted.

## Timing
- Reset values: in_ready=1, out_valid=0, result=0, zero=0, err=0, ovf=0, err_count=0. All pipeline valids are cleared.
- Latency: input transfer at edge N gives out_valid high after edge N+1 (2-stage, one cycle between edges). With out_ready held high, results appear in the order accepted, one per cycle.
- Backpressure: with out_ready low, at most 2 ops are held (S1 + S2). in_ready drops once both stages are full.
- Reset asserted mid-operation: all in-flight ops are discarded, err_count is cleared, and reset values apply from the next cycle. No output transfer is reported in the reset cycle.
- in_valid asserted while reset is high is ignored.

## Configuration
- Macro ALU_OVF_EN.
- When defined, the ovf port exists and is set for signed overflow on add/sub:
  - add: operand signs equal and result sign differs
  - sub: operand signs differ and result sign differs from a
  - ovf is 0 for all other ops.
- When undefined, the ovf port and its logic are absent; all other behaviour is identical.

## Test plan
- Reset then add: a=5, b=7, ctrl=1, out_ready=1 -> result=12, zero=0, err=0 after 2 edges; in_ready=1 throughout.
- Back-to-back: sub a=3, b=3 (ctrl 2); slt a=-1, b=1 (ctrl 5); AND a=0xF0F0, b=0x0FF0 (ctrl 3); one per cycle -> results 0 with zero=1, then 1, then 0x00F0, on consecutive cycles.
- Backpressure: out_ready=0, offer 3 ops -> 2 accepted, then in_ready=0. result is stable holding the first op. Releasing out_ready drains both in order and the third op is then accepted.
- Illegal codes: ctrl 0, 6, 7 -> each gives result=0, err=1. err_count reaches 3. After 260 illegal ops err_count=255.
- Reset mid-flight: 2 ops pending with out_ready=0, assert reset for 1 cycle -> out_valid=0, err_count=0, in_ready=1. No stale result appears afterwards.
- With ALU_OVF_EN: add 0x7FFFFFFF+1 -> result 0x80000000, ovf=1. sub 0x80000000-1 -> ovf=1. OR op -> ovf=0.
